// File: rtl/mode_ctrl_io.sv
// Board-side user I/O: two debounced mode buttons with short/long press
// classification, a next-long mode lock, and a stretched comm-activity LED.
module mode_ctrl_io #(
    parameter int MODE_COUNT        = 4,
    parameter int BTN_ACTIVE_LOW    = 1,
    parameter int DEBOUNCE_COUNT    = 65536,
    parameter int LONG_PRESS_COUNT  = 16777216,
    parameter int LED_STRETCH_COUNT = 1048576
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  next_btn,
    input  logic                  prev_btn,
    input  logic                  comm_active,
    output logic [MODE_COUNT-1:0] mode_select,
    output logic                  mode_changed,
    output logic [MODE_COUNT-1:0] mode_leds,
    output logic                  lock_led,
    output logic                  comm_active_led
);

    localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
    localparam int HW = $clog2(LONG_PRESS_COUNT + 1);
    localparam int SW = (LED_STRETCH_COUNT > 0) ? $clog2(LED_STRETCH_COUNT + 1) : 1;

    localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_COUNT - 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(LONG_PRESS_COUNT - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(LED_STRETCH_COUNT);
    localparam logic          RAW_IDLE     = (BTN_ACTIVE_LOW != 0);
    localparam int            NXT          = 0;
    localparam int            PRV          = 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } pressState_t;

    logic [1:0]            btnMeta_q;
    logic [1:0]            btnSync_q;
    logic [1:0]            btnPressed;
    logic                  commMeta_q;
    logic                  commSync_q;
    logic [1:0]            debLvl_q;
    logic [DW-1:0]         debCnt_q [2];
    pressState_t           pressState_q [2];
    logic [HW-1:0]         holdCnt_q [2];
    logic [1:0]            shortEv_q;
    logic                  nextLongEv_q;
    logic [MODE_COUNT-1:0] modeSel_q;
    logic [MODE_COUNT-1:0] modeSel_d;
    logic                  modeChanged_q;
    logic                  modeChanged_d;
    logic                  lock_q;
    logic                  lock_d;
    logic [SW-1:0]         stretchCnt_q;
    logic                  led_q;

    // Button synchronizers reset to the released pin level so reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btnMeta_q  <= {2{RAW_IDLE}};
            btnSync_q  <= {2{RAW_IDLE}};
            commMeta_q <= 1'b0;
            commSync_q <= 1'b0;
        end else begin
            btnMeta_q  <= {prev_btn, next_btn};
            btnSync_q  <= btnMeta_q;
            commMeta_q <= comm_active;
            commSync_q <= commMeta_q;
        end
    end

    assign btnPressed = btnSync_q ^ {2{RAW_IDLE}};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            debLvl_q <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                debCnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (btnPressed[b] != debLvl_q[b]) begin
                    if (debCnt_q[b] == DEB_LAST) begin
                        debLvl_q[b] <= btnPressed[b];
                        debCnt_q[b] <= '0;
                    end else begin
                        debCnt_q[b] <= debCnt_q[b] + 1'b1;
                    end
                end else begin
                    debCnt_q[b] <= '0;
                end
            end
        end
    end

    // Press classifier per button; only next's long event has a consumer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shortEv_q    <= 2'b00;
            nextLongEv_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                pressState_q[b] <= IDLE;
                holdCnt_q[b]    <= '0;
            end
        end else begin
            shortEv_q    <= 2'b00;
            nextLongEv_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                case (pressState_q[b])
                    IDLE: begin
                        if (debLvl_q[b]) begin
                            pressState_q[b] <= PRESSED;
                            holdCnt_q[b]    <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!debLvl_q[b]) begin
                            shortEv_q[b]    <= 1'b1;
                            pressState_q[b] <= IDLE;
                        end else if (holdCnt_q[b] == HOLD_LAST) begin
                            holdCnt_q[b]    <= holdCnt_q[b] + 1'b1;
                            pressState_q[b] <= LONG;
                            if (b == NXT) begin
                                nextLongEv_q <= 1'b1;
                            end
                        end else begin
                            holdCnt_q[b] <= holdCnt_q[b] + 1'b1;
                        end
                    end
                    LONG: begin
                        if (!debLvl_q[b]) begin
                            pressState_q[b] <= IDLE;
                        end
                    end
                    default: pressState_q[b] <= IDLE;
                endcase
            end
        end
    end

    // Short events are judged against the lock state before any same-cycle toggle.
    always_comb begin
        modeSel_d     = modeSel_q;
        modeChanged_d = 1'b0;
        lock_d        = lock_q ^ nextLongEv_q;
        if (!lock_q) begin
            if (shortEv_q[NXT] && !shortEv_q[PRV]) begin
                modeSel_d     = {modeSel_q[MODE_COUNT-2:0], modeSel_q[MODE_COUNT-1]};
                modeChanged_d = 1'b1;
            end else if (shortEv_q[PRV] && !shortEv_q[NXT]) begin
                modeSel_d     = {modeSel_q[0], modeSel_q[MODE_COUNT-1:1]};
                modeChanged_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            modeSel_q     <= MODE_COUNT'(1);
            modeChanged_q <= 1'b0;
            lock_q        <= 1'b0;
        end else begin
            modeSel_q     <= modeSel_d;
            modeChanged_q <= modeChanged_d;
            lock_q        <= lock_d;
        end
    end

    // Activity keeps the stretch loaded, so a re-rise mid-stretch leaves no gap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stretchCnt_q <= '0;
            led_q        <= 1'b0;
        end else if (commSync_q) begin
            stretchCnt_q <= STRETCH_LOAD;
            led_q        <= 1'b1;
        end else if (stretchCnt_q != '0) begin
            stretchCnt_q <= stretchCnt_q - 1'b1;
            led_q        <= 1'b1;
        end else begin
            led_q <= 1'b0;
        end
    end

    assign mode_select     = modeSel_q;
    assign mode_leds       = modeSel_q;
    assign mode_changed    = modeChanged_q;
    assign lock_led        = lock_q;
    assign comm_active_led = led_q;

endmodule

// File: doc/mode_ctrl_io.md
Name: mode_ctrl_io

Overview:
Next-generation user I/O front end for the MITM board. It replaces the single-button cyclic mode selector with two debounced buttons (next/prev) and short/long press classification. A long press on next toggles a mode lock. It also stretches the comm-activity LED so short bursts stay visible. It sits between board pins and the MITM logic module and drives the one-hot mode_select consumed there.

Parameters:
MODE_COUNT, 4, number of modes; mode_select is one-hot of this width; legal range ≥2
BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed
DEBOUNCE_COUNT, 65536, consecutive stable cycles required to accept a button level change; ≥1
LONG_PRESS_COUNT, 16777216, cycles a debounced press must be held to count as long; > DEBOUNCE_COUNT
LED_STRETCH_COUNT, 1048576, cycles comm_active_led stays lit after comm_active falls; 0 = no stretch

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
next_btn  in  1  raw async button, select next mode
prev_btn  in  1  raw async button, select previous mode
comm_active  in  1  async/sync activity flag from MITM logic
mode_select  out  MODE_COUNT  one-hot current mode
mode_changed  out  1  single-cycle pulse when mode_select changes
mode_leds  out  MODE_COUNT  equals mode_select
lock_led  out  1  1 while mode lock is engaged
comm_active_led  out  1  stretched activity indication

Behaviour:
- Reset (async assert, sync-released by design clocking): mode_select = 1 (bit 0), mode_changed = 0, lock = 0, comm_active_led = 0, all counters 0, all FSMs IDLE, debounced levels = released.
- Each raw input passes a 2-flop synchronizer. Button polarity is normalised after sync: pressed = 1.
- Debounce, per button: a counter increments while the synced level ≠ the debounced level, and clears when they are equal. When the count reaches DEBOUNCE_COUNT, the debounced level takes the synced level and the counter clears. A glitch shorter than DEBOUNCE_COUNT cycles produces no change.
- Press FSM, per button, on the debounced level:
  - IDLE → PRESSED on debounced rise; hold counter = 0.
  - PRESSED: hold counter increments each cycle.
  - PRESSED, debounced fall before the count reaches LONG_PRESS_COUNT → emit short event for 1 cycle → IDLE.
  - PRESSED, count reaches LONG_PRESS_COUNT → emit long event for 1 cycle → LONG.
  - LONG → IDLE on debounced fall; no further event.
  - Counter saturates; no wrap.
- Actions, registered 1 cycle after the event cycle:
  - next short, unlocked: rotate mode_select left (MSB wraps to bit 0).
  - prev short, unlocked: rotate right (bit 0 wraps to MSB).
  - Both short events in the same cycle: no change, no pulse.
  - Any short event while locked: ignored.
  - next long: toggle lock, with no mode change; this applies whether locked or not.
  - prev long: no action.
  - next long and prev short in the same cycle: lock toggles; the prev short is evaluated against the lock state before the toggle.
- mode_changed is high exactly in the cycle mode_select takes its new value.
- mode_select is always one-hot; there is no illegal-state recovery beyond reset.
- comm_active_led:
  - High while synced comm_active = 1.
  - On its fall, stays high for LED_STRETCH_COUNT further cycles, then goes low.
  - A re-rise during the stretch reloads the stretch, with no gap.
- Reset mid-press: FSMs return to IDLE. A button still held at release of reset needs a full debounce and then counts as a fresh press.
- Latency from raw press-release to mode change: 2 sync cycles + DEBOUNCE_COUNT for the release + 1 event cycle + 1 action cycle.

Test Plan:
(Bench parameters: MODE_COUNT=4, DEBOUNCE_COUNT=4, LONG_PRESS_COUNT=20, LED_STRETCH_COUNT=8, BTN_ACTIVE_LOW=1.)
- Reset → mode_select=4'b0001, lock_led=0, comm_active_led=0. Assert sys_rst_n=0 mid-operation → outputs return to these values immediately (async).
- next_btn low for 10 cycles then high → mode_select 0001→0010 with one mode_changed pulse. Repeat 3 more times → 0100, 1000, 0001 (wrap).
- prev_btn short press from 0001 → 1000. A 3-cycle low glitch on prev_btn → no change, no pulse.
- next_btn held 40 cycles → lock_led=1 and mode unchanged. Next then prev short presses → no change. Another long next → lock_led=0.
- next and prev released on the same cycle after equal short holds → mode_select unchanged, mode_changed stays 0.
- comm_active 1 for 2 cycles → comm_active_led high for those cycles + 8 after, then 0. Re-pulse at stretch cycle 5 → led stays continuously high, and the stretch restarts.
